// File: rtl/fixed_point_add_arbiter_pkg.sv
// Shared fixed-point types, saturation limits and arbiter state encoding.
// FIXED_W defaults to 32 (Q16.16) unless the build defines it.
`ifndef FIXED_W
`define FIXED_W 32
`endif

package fixed_point_add_arbiter_pkg;
  typedef logic signed [`FIXED_W-1:0] fixed_point_t;

  localparam fixed_point_t FIXED_MAX = {1'b0, {(`FIXED_W-1){1'b1}}};
  localparam fixed_point_t FIXED_MIN = {1'b1, {(`FIXED_W-1){1'b0}}};

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;
endpackage

// File: rtl/fixed_point_add_arbiter_if.sv
// Request/response bundle between NUM_REQ clients and the shared adder.
interface fixed_point_add_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int OVF_CNT_W = 16
);
  import fixed_point_add_arbiter_pkg::*;

  localparam int ID_W = $clog2(NUM_REQ);

  logic         [NUM_REQ-1:0] req_valid;
  fixed_point_t [NUM_REQ-1:0] req_op1;
  fixed_point_t [NUM_REQ-1:0] req_op2;
  logic         [NUM_REQ-1:0] req_ready;
  logic                       rsp_valid;
  logic                       rsp_ready;
  fixed_point_t               rsp_result;
  logic                       rsp_overflow;
  logic         [ID_W-1:0]    rsp_id;
  logic         [OVF_CNT_W-1:0] ovf_count;
  logic                       ovf_clear;

  modport master (
    output req_valid, req_op1, req_op2, rsp_ready, ovf_clear,
    input  req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_id, ovf_count
  );

  modport slave (
    input  req_valid, req_op1, req_op2, rsp_ready, ovf_clear,
    output req_ready, rsp_valid, rsp_result, rsp_overflow, rsp_id, ovf_count
  );
endinterface

// File: rtl/fixed_point_add.sv
// Combinational two's-complement adder with signed-overflow detect.
module fixed_point_add
  import fixed_point_add_arbiter_pkg::*;
(
  input  fixed_point_t a,
  input  fixed_point_t b,
  output fixed_point_t sum,
  output logic         overflow
);
  assign sum      = a + b;
  assign overflow = (a[`FIXED_W-1] == b[`FIXED_W-1]) && (sum[`FIXED_W-1] != a[`FIXED_W-1]);
endmodule

// File: rtl/fixed_point_add_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after rr_ptr, with wrap.
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);
  localparam logic [ID_W:0] NREQ_W = (ID_W+1)'(NUM_REQ);

  logic            found;
  logic [ID_W:0]   wide;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    wide      = '0;
    idx       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wide = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (wide >= NREQ_W) wide = wide - NREQ_W;
      idx = wide[ID_W-1:0];
      if (enable && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end
endmodule

// File: rtl/fixed_point_add_arbiter.sv
// Round-robin shared fixed-point adder with a one-entry registered response.
// Optional macro FIXED_ADD_SATURATE_EN clamps overflowing sums to FIXED_MAX/FIXED_MIN.
module fixed_point_add_arbiter
  import fixed_point_add_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int OVF_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fixed_point_add_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);
`ifdef FIXED_ADD_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  arb_state_t      state;
  logic [ID_W-1:0] rr_ptr;
  logic            can_accept;
  logic            grant_vld;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0] grant_idx;
  fixed_point_t    op1_p0, op2_p0, sum_p0;
  logic            ovf_p0;

  function automatic fixed_point_t saturate(fixed_point_t a, fixed_point_t sum, logic ovf);
    if (SAT_EN && ovf) return a[`FIXED_W-1] ? FIXED_MIN : FIXED_MAX;
    return sum;
  endfunction

  // Held in reset, the arbiter grants nothing even though state reads EMPTY.
  assign can_accept = rst_n & ((state == EMPTY) | (bus.rsp_valid & bus.rsp_ready));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .enable    (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign bus.req_ready = grant;
  assign grant_vld     = |grant;
  assign op1_p0        = bus.req_op1[grant_idx];
  assign op2_p0        = bus.req_op2[grant_idx];

  fixed_point_add u_fixed_point_add (
    .a        (op1_p0),
    .b        (op2_p0),
    .sum      (sum_p0),
    .overflow (ovf_p0)
  );

  // p0 -> response register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= EMPTY;
      rr_ptr           <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_id       <= '0;
      bus.ovf_count    <= '0;
    end else begin
      if (grant_vld) begin
        state            <= FULL;
        bus.rsp_valid    <= 1'b1;
        bus.rsp_result   <= saturate(op1_p0, sum_p0, ovf_p0);
        bus.rsp_overflow <= ovf_p0;
        bus.rsp_id       <= grant_idx;
        rr_ptr           <= (grant_idx == ID_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end else if (bus.rsp_valid && bus.rsp_ready) begin
        state         <= EMPTY;
        bus.rsp_valid <= 1'b0;
      end

      if (bus.ovf_clear)
        bus.ovf_count <= '0;
      else if (grant_vld && ovf_p0 && (bus.ovf_count != '1))
        bus.ovf_count <= bus.ovf_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_fixed_point_add_arbiter.sv
// Directed bench for fixed_point_add_arbiter with a per-cycle reference model.
module tb_fixed_point_add_arbiter;
  import fixed_point_add_arbiter_pkg::*;

`ifdef FIXED_ADD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fixed_point_add_arbiter_if #(.NUM_REQ(4), .OVF_CNT_W(16)) bus ();

  fixed_point_add_arbiter #(.NUM_REQ(4), .OVF_CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic int pick(input logic [3:0] v, input int ptr, input bit en);
    if (!en) return -1;
    for (int i = 0; i < 4; i++) begin
      int j;
      j = (ptr + i) % 4;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic void model_add(input fixed_point_t a, input fixed_point_t b,
                                    output fixed_point_t r, output bit o);
    longint s;
    s = longint'(a) + longint'(b);
    o = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
    r = fixed_point_t'(s[31:0]);
    if (o && SAT) r = (s > 0) ? FIXED_MAX : FIXED_MIN;
  endfunction

  // Reference model: one response slot, rotating priority, saturating counter.
  int           m_ptr, m_id, m_cnt;
  bit           m_full, m_ovf;
  fixed_point_t m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr <= 0; m_full <= 0; m_res <= '0; m_ovf <= 0; m_id <= 0; m_cnt <= 0;
    end else begin : upd
      int g;
      fixed_point_t r;
      bit o;
      o = 0;
      r = '0;
      g = pick(bus.req_valid, m_ptr, !m_full || bus.rsp_ready);
      if (g >= 0) begin
        model_add(bus.req_op1[g[1:0]], bus.req_op2[g[1:0]], r, o);
        m_res <= r; m_ovf <= o; m_id <= g; m_full <= 1; m_ptr <= (g + 1) % 4;
      end else if (m_full && bus.rsp_ready) begin
        m_full <= 0;
      end
      if (bus.ovf_clear) m_cnt <= 0;
      else if (g >= 0 && o && m_cnt < 65535) m_cnt <= m_cnt + 1;
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    logic [3:0] exp_ready;
    if (!rst_n) begin
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end else begin
      g = pick(bus.req_valid, m_ptr, !m_full || bus.rsp_ready);
      exp_ready = (g >= 0) ? 4'(1 << g) : 4'd0;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_full));
      if (m_full) begin
        chk("rsp_result", bus.rsp_result, m_res);
        chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(m_ovf));
        chk("rsp_id", 32'(bus.rsp_id), 32'(m_id));
      end
      chk("ovf_count", 32'(bus.ovf_count), 32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 4'hF;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.rsp_ready = 1'b0;
    bus.ovf_clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset_rsp_result", bus.rsp_result, 32'd0);
    chk("reset_ovf_count", 32'(bus.ovf_count), 32'd0);
    bus.req_valid = 4'h0;
    rst_n = 1'b1;

    // single operation
    step();
    bus.req_op1[0] = 32'h0001_0000;
    bus.req_op2[0] = 32'h0002_0000;
    bus.rsp_ready  = 1'b1;
    bus.req_valid  = 4'b0001;
    #1 chk("single_grant", 32'(bus.req_ready), 32'h1);
    step();
    bus.req_valid = 4'b0000;
    chk("single_valid", 32'(bus.rsp_valid), 32'd1);
    chk("single_result", bus.rsp_result, 32'h0003_0000);
    chk("single_ovf", 32'(bus.rsp_overflow), 32'd0);
    chk("single_id", 32'(bus.rsp_id), 32'd0);
    step();
    chk("single_drain", 32'(bus.rsp_valid), 32'd0);

    // fairness
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_op1[i] = 32'(i) << 16;
      bus.req_op2[i] = 32'h0001_0000;
    end
    bus.req_valid = 4'hF;
    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1 chk("fair_grant", 32'(bus.req_ready), 32'(1 << (k % 4)));
      step();
      if (k == 1) begin
        chk("fair_id", 32'(bus.rsp_id), 32'd1);
        chk("fair_result", bus.rsp_result, 32'h0002_0000);
      end
    end

    // backpressure: requester 3's result must hold
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("bp_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_id", 32'(bus.rsp_id), 32'd3);
      chk("bp_result", bus.rsp_result, 32'h0004_0000);
      step();
    end
    bus.rsp_ready = 1'b1;
    bus.req_valid = 4'b0100;
    #1 chk("bp_regrant", 32'(bus.req_ready), 32'b0100);
    step();
    bus.req_valid = 4'b0000;
    chk("bp_new_id", 32'(bus.rsp_id), 32'd2);
    chk("bp_new_result", bus.rsp_result, 32'h0003_0000);
    step();

    // overflow
    do_reset();
    bus.req_op1[0] = 32'h7FFF_0000;
    bus.req_op2[0] = 32'h0001_0000;
    bus.req_valid  = 4'b0001;
    step();
    bus.req_valid = 4'b0000;
    chk("ovf_pos_flag", 32'(bus.rsp_overflow), 32'd1);
    chk("ovf_pos_count", 32'(bus.ovf_count), 32'd1);
    chk("ovf_pos_result", bus.rsp_result, SAT ? 32'h7FFF_FFFF : 32'h8000_0000);
    bus.req_op1[1] = 32'h8000_0000;
    bus.req_op2[1] = 32'hFFFF_0000;
    bus.req_valid  = 4'b0010;
    step();
    bus.req_valid = 4'b0000;
    chk("ovf_neg_flag", 32'(bus.rsp_overflow), 32'd1);
    chk("ovf_neg_result", bus.rsp_result, SAT ? 32'h8000_0000 : 32'h7FFF_0000);
    chk("ovf_neg_count", 32'(bus.ovf_count), 32'd2);

    // counter saturation and clear priority
    do_reset();
    bus.req_valid = 4'b0001;
    repeat (65539) step();
    bus.req_valid = 4'b0000;
    chk("cnt_saturated", 32'(bus.ovf_count), 32'h0000_FFFF);
    step();
    bus.ovf_clear = 1'b1;
    bus.req_valid = 4'b0001;
    step();
    bus.ovf_clear = 1'b0;
    bus.req_valid = 4'b0000;
    chk("cnt_clear_wins", 32'(bus.ovf_count), 32'd0);
    chk("cnt_clear_flag", 32'(bus.rsp_overflow), 32'd1);

    // asynchronous reset while FULL
    step();
    bus.req_op1[0] = 32'h0001_0000;
    bus.req_op2[0] = 32'h0002_0000;
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 4'b0001;
    step();
    bus.req_valid = 4'b1010;
    chk("midop_full", 32'(bus.rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("midop_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midop_req_ready", 32'(bus.req_ready), 32'd0);
    step();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 chk("midop_first_grant", 32'(bus.req_ready), 32'b0010);
    step();
    bus.req_valid = 4'b0000;
    chk("midop_id", 32'(bus.rsp_id), 32'd1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fixed_point_add_arbiter.md
Name: fixed_point_add_arbiter

Overview:
Shares a single fixed_point_add instance between NUM_REQ requesters using round-robin arbitration and valid/ready handshakes.
- Each granted operation produces one registered response tagged with the requester id and the overflow flag.
- A sticky saturating counter records overflow events.
- Sits between the rasteriser/vertex stages and the fixed-point datapath, wherever several clients need occasional adds.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- OVF_CNT_W, 16, width of the overflow event counter.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_op1  in  NUM_REQ x fixed_point_t  packed array, first operands.
- req_op2  in  NUM_REQ x fixed_point_t  packed array, second operands.
- req_ready  out  NUM_REQ  one-hot grant; the op is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  1  response register holds a result.
- rsp_ready  in  1  downstream accepts the response.
- rsp_result  out  fixed_point_t  sum, `FIXED_W bits.
- rsp_overflow  out  1  signed overflow of this operation.
- rsp_id  out  $clog2(NUM_REQ)  index of the originating requester.
- ovf_count  out  OVF_CNT_W  overflow events since reset or clear.
- ovf_clear  in  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst_n low, asynchronous): rsp_valid=0, rsp_result=0, rsp_overflow=0, rsp_id=0, ovf_count=0, rr_ptr=0, state=EMPTY. req_ready=0 while in reset.
- States:
  - EMPTY: response register free.
  - FULL: response register holds an unconsumed result.
- can_accept = (state==EMPTY) | (rsp_valid & rsp_ready).
- Grant (combinational, same cycle):
  - When can_accept and any req_valid is high, grant the first valid index at or after rr_ptr, searching upward with wrap-around.
  - req_ready is one-hot at that index; all other bits are 0.
  - When can_accept=0, req_ready=0. req_ready never depends on rsp_ready except via can_accept.
- On a grant edge:
  - Operands of the granted index drive the shared adder.
  - result, overflow and id are registered; rsp_valid=1; state=FULL.
  - rr_ptr = (granted+1) mod NUM_REQ.
  - Latency: 1 cycle from accept to rsp_valid.
- Drain and refill:
  - FULL & rsp_ready & no req_valid: rsp_valid=0, state=EMPTY.
  - FULL & rsp_ready & some req_valid: back-to-back refill in the same cycle; throughput is 1 op/cycle.
- FULL & !rsp_ready: rsp_result, rsp_overflow and rsp_id are stable; req_ready=0.
- Arithmetic:
  - Wrap-around two's complement at `FIXED_W bits.
  - Overflow = operands share a sign and the result sign differs.
- ovf_count:
  - Increments by 1 on each grant whose overflow=1; saturates at all-ones.
  - ovf_clear has priority over increment; clear and overflow in the same cycle yields 0.
- Requester deasserting req_valid without a grant is legal; no state is held for it.
- Reset mid-operation: a pending response is discarded; no partial state survives.

Optional Feature:
Macro: FIXED_ADD_SATURATE_EN.
- Defined: when overflow=1, rsp_result clamps to the most positive value (both operands non-negative) or the most negative value (both negative). rsp_overflow and ovf_count still report the event.
- Undefined: rsp_result is the wrapped sum.

Decomposition:
- Package fixed_point holds fixed_point_t and `FIXED_W, as today.
- Add to the package:
  - localparam FIXED_MAX / FIXED_MIN, used for saturation.
  - arb_state_t enum {EMPTY, FULL}.
- One sub-module: rr_arbiter, a pure combinational round-robin one-hot picker.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: grant one-hot, grant index.
- fixed_point_add is instantiated once, unchanged.

Test Plan:
(FIXED_W=32, Q16.16, NUM_REQ=4)
- Single op: req_valid=0001, op1=0x00010000, op2=0x00020000, rsp_ready=1 → req_ready=0001 same cycle; next cycle rsp_valid=1, result=0x00030000, overflow=0, id=0.
- Fairness: all 4 valid continuously, rsp_ready=1 → grants 0,1,2,3,0,… one per cycle. rr_ptr starts at 0 after reset.
- Backpressure: rsp_ready=0 for 5 cycles with result held → req_ready=0000, rsp_* stable. rsp_ready=1 with req_valid=0100 → same-cycle grant to 2; new result the following cycle.
- Overflow: 0x7FFF0000+0x00010000 → overflow=1, ovf_count=1. Result 0x80000000, or 0x7FFFFFFF with FIXED_ADD_SATURATE_EN. 0x80000000+0xFFFF0000 → overflow=1; saturated result 0x80000000.
- Counter: force 2^16+3 overflows → ovf_count=0xFFFF. ovf_clear asserted in the same cycle as an overflow → ovf_count=0.
- Reset mid-op: assert rst_n low while FULL → rsp_valid=0 immediately (async); after release, first grant goes to the lowest valid index.
